// File: rtl/route_req_queue.sv
// route_req_queue: FIFO-buffered route request issuer for the 4-lane router.
// Requests are queued from the controller, presented one at a time on the
// router_* interface and reported back with a one-cycle done pulse.
// Optional request timeout: compile with `define ROUTE_REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | queue empty, router_start_req low, router_* hold last request
// REQ   | head entry presented, router_start_req held until ack (or timeout)
// GAP   | one cycle with router_start_req low after a completion
module route_req_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 10,
    parameter int DFX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_src_addr,
    input  logic [ADDR_W-1:0]      in_dst_addr,
    input  logic [DFX_W-1:0]       in_src_dfx,
    input  logic [DFX_W-1:0]       in_dst_dfx,
    output logic [ADDR_W-1:0]      router_scr_addr,
    output logic [ADDR_W-1:0]      router_dst_addr,
    output logic [DFX_W-1:0]       router_src_dfx,
    output logic [DFX_W-1:0]       router_dst_dfx,
    output logic                   router_start_req,
    input  logic                   router_ack,
    output logic                   done_valid,
    output logic                   done_timeout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = 2 * ADDR_W + 2 * DFX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    logic [E_W-1:0]   mem_q [DEPTH];
    logic [E_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [E_W-1:0]   req_q, req_d;
    logic             start_q, start_d;
    logic             done_valid_q, done_valid_d;
    logic             push, pop;

`ifdef ROUTE_REQ_TIMEOUT_EN
    // Down-counter loaded on REQ entry; terminal count marks the TIMEOUT-th REQ cycle.
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             done_timeout_q, done_timeout_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign count    = count_q;

    assign {router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx} = req_q;
    assign router_start_req = start_q;
    assign done_valid       = done_valid_q;
`ifdef ROUTE_REQ_TIMEOUT_EN
    assign done_timeout     = done_timeout_q;
`else
    assign done_timeout     = 1'b0;
`endif

    // FIFO storage, pointers and occupancy next state (pop driven by the FSM)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_src_addr, in_dst_addr, in_src_dfx, in_dst_dfx};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Request FSM next state; IDLE and GAP both issue the head when the queue is non-empty
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        start_d      = start_q;
        done_valid_d = 1'b0;
        pop          = 1'b0;
`ifdef ROUTE_REQ_TIMEOUT_EN
        tmr_d          = tmr_q;
        done_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_GAP: begin
                if (count_q != '0) begin
                    req_d   = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = S_REQ;
`ifdef ROUTE_REQ_TIMEOUT_EN
                    tmr_d   = TMR_LOAD;
`endif
                end else begin
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (router_ack) begin
                    pop          = 1'b1;
                    done_valid_d = 1'b1;
                    start_d      = 1'b0;
                    state_d      = S_GAP;
                end
`ifdef ROUTE_REQ_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    pop            = 1'b1;
                    done_valid_d   = 1'b1;
                    done_timeout_d = 1'b1;
                    start_d        = 1'b0;
                    state_d        = S_GAP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
`endif
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO storage needs no reset: entries are only read when count is non-zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control registers with synchronous reset; reset drops any in-flight request silently
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            req_q        <= '0;
            start_q      <= 1'b0;
            done_valid_q <= 1'b0;
`ifdef ROUTE_REQ_TIMEOUT_EN
            tmr_q          <= '0;
            done_timeout_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            req_q        <= req_d;
            start_q      <= start_d;
            done_valid_q <= done_valid_d;
`ifdef ROUTE_REQ_TIMEOUT_EN
            tmr_q          <= tmr_d;
            done_timeout_q <= done_timeout_d;
`endif
        end
    end

endmodule
